viterbi_rx: RTL and testbench

//  Hard-decision Viterbi receiver for the K=3, rate-1/2 convolutional code (G0=111, G1=101) sent by
//  the serial encoder. Takes the 1-bit/clock coded stream (c0 then c1 per info bit), rebuilds symbols,

---
 rtl/viterbi_rx.sv | 119 +++++++++++
 tb/tb_viterbi_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/viterbi_rx.sv
// Hard-decision Viterbi receiver for the K=3, rate-1/2 code (G0=111, G1=101).
// Rebuilds symbols from the serial coded stream; 4-state ACS with register-exchange survivors.
module viterbi_rx #(
    parameter int D = 16,
    parameter int W = 6
) (
    input  logic Clock,
    input  logic reset,
    input  logic in,
    output logic decoded,
    output logic valid,
    output logic error
);
    // state | meaning
    // PH_C0 | waiting for c0 of the next symbol
    // PH_C1 | c0 held; this edge completes the symbol and runs ACS
    typedef enum logic {PH_C0 = 1'b0, PH_C1 = 1'b1} phase_t;

    localparam int              CW       = $clog2(D + 1);
    localparam logic [W-1:0]    PM_MAX   = {W{1'b1}};
    localparam logic [W-1:0]    PM_INIT  = W'(8);
    localparam logic [CW-1:0]   CNT_FULL = CW'(D);

    phase_t        phase_q, phase_d;
    logic          c0_q, c0_d;
    logic [W-1:0]  pm_q [4];
    logic [W-1:0]  pm_d [4];
    logic [D-2:0]  sv_q [4];
    logic [D-2:0]  sv_d [4];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          decoded_q, decoded_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    logic [1:0]    bm     [4][2];
    logic [W:0]    sum    [4][2];
    logic [W-1:0]  cand   [4][2];
    logic [W-1:0]  win    [4];
    logic [1:0]    pred   [4];
    logic [D-1:0]  sv_ext [4];
    logic [W-1:0]  pm_new [4];
    logic [W-1:0]  pm_min;
    logic [1:0]    best;

    // Next state n = {u, a}; predecessors {a, b}; expected pair c0 = u^a^b, c1 = u^b.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            for (int b = 0; b < 2; b++) begin
                bm[n][b]   = {1'b0, c0_q ^ n[1] ^ n[0] ^ b[0]} + {1'b0, in ^ n[1] ^ b[0]};
                sum[n][b]  = {1'b0, pm_q[{n[0], b[0]}]} + {{(W-1){1'b0}}, bm[n][b]};
                cand[n][b] = (sum[n][b] >= {1'b0, PM_MAX}) ? PM_MAX : sum[n][b][W-1:0];
            end
            pred[n]   = (cand[n][1] < cand[n][0]) ? {n[0], 1'b1} : {n[0], 1'b0};
            win[n]    = (cand[n][1] < cand[n][0]) ? cand[n][1] : cand[n][0];
            sv_ext[n] = {sv_q[pred[n]], n[1]};
        end
        pm_min = win[0];
        for (int n = 1; n < 4; n++) begin
            if (win[n] < pm_min) pm_min = win[n];
        end
        for (int n = 0; n < 4; n++) begin
            pm_new[n] = win[n] - pm_min;
        end
        best = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (pm_new[n] < pm_new[best]) best = 2'(n);
        end
    end

    always_comb begin
        phase_d   = (phase_q == PH_C0) ? PH_C1 : PH_C0;
        c0_d      = c0_q;
        pm_d      = pm_q;
        sv_d      = sv_q;
        cnt_d     = cnt_q;
        decoded_d = decoded_q;
        valid_d   = valid_q;
        error_d   = 1'b0;
        if (phase_q == PH_C0) begin
            c0_d = in;
        end else begin
            for (int n = 0; n < 4; n++) begin
                pm_d[n] = pm_new[n];
                sv_d[n] = sv_ext[n][D-2:0];
            end
            cnt_d     = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
            valid_d   = valid_q | (cnt_d == CNT_FULL);
            decoded_d = sv_ext[best][D-1];
            error_d   = (pm_min != '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            phase_q   <= PH_C0;
            c0_q      <= 1'b0;
            pm_q[0]   <= '0;
            for (int n = 1; n < 4; n++) pm_q[n] <= PM_INIT;
            for (int n = 0; n < 4; n++) sv_q[n] <= '0;
            cnt_q     <= '0;
            decoded_q <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            c0_q      <= c0_d;
            pm_q      <= pm_d;
            sv_q      <= sv_d;
            cnt_q     <= cnt_d;
            decoded_q <= decoded_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign decoded = decoded_q;
    assign valid   = valid_q;
    assign error   = error_q;
endmodule

// File: tb/tb_viterbi_rx.sv
// Bench for viterbi_rx: a reference encoder feeds the DUT; sent info bits queue up and
// are compared against decoded output once valid is set.
module tb_viterbi_rx;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic decoded, valid, error;

    int n_cmp = 0;
    int n_bad = 0;
    int sym_cnt = 0;
    int err_pulses = 0;
    bit exp_q[$];
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;

    viterbi_rx #(.D(D), .W(6)) dut (
        .Clock  (clk),
        .reset  (rst),
        .in     (din),
        .decoded(decoded),
        .valid  (valid),
        .error  (error)
    );

    always #5 clk = ~clk;

    task automatic clk_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic bench_clear();
        sym_cnt = 0;
        exp_q.delete();
        enc_a = 1'b0;
        enc_b = 1'b0;
    endtask

    // err_mode: 0 -> error must be 0, 1 -> error must be 1, 2 -> count pulses only
    task automatic send_sym(input logic c0, input logic c1, input logic u, input bit track,
                            input int err_mode, input string tag);
        logic dec_before, val_before;
        bit   exp_bit;
        dec_before = decoded;
        val_before = valid;
        clk_bit(c0);
        n_cmp++;
        if (error !== 1'b0 || decoded !== dec_before || valid !== val_before) begin
            n_bad++;
            $display("FAIL %s phase0_hold sym %0d: got err=%b dec=%b val=%b, want err=0 dec=%b val=%b",
                     tag, sym_cnt + 1, error, decoded, valid, dec_before, val_before);
        end
        clk_bit(c1);
        sym_cnt++;
        if (track) exp_q.push_back(u);
        n_cmp++;
        if (valid !== (sym_cnt >= D)) begin
            n_bad++;
            $display("FAIL %s valid sym %0d: got %b, want %b", tag, sym_cnt, valid, sym_cnt >= D);
        end
        if (err_mode == 2) begin
            if (error === 1'b1) err_pulses++;
        end else begin
            n_cmp++;
            if (error !== err_mode[0]) begin
                n_bad++;
                $display("FAIL %s error sym %0d: got %b, want %b", tag, sym_cnt, error, err_mode[0]);
            end
        end
        if (track && valid === 1'b1 && exp_q.size() > 0) begin
            exp_bit = exp_q.pop_front();
            n_cmp++;
            if (decoded !== exp_bit) begin
                n_bad++;
                $display("FAIL %s decoded sym %0d: got %b, want %b", tag, sym_cnt, decoded, exp_bit);
            end
        end
    endtask

    task automatic send_info(input logic u, input bit flip_c1, input int err_mode, input string tag);
        logic c0, c1;
        c0 = u ^ enc_a ^ enc_b;
        c1 = u ^ enc_b ^ flip_c1;
        enc_b = enc_a;
        enc_a = u;
        send_sym(c0, c1, u, 1'b1, err_mode, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bench_clear();
    endtask

    task automatic check_zero_outputs(input string tag);
        n_cmp++;
        if (decoded !== 1'b0 || valid !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got dec=%b val=%b err=%b, want all 0", tag, decoded, valid, error);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_zero_outputs("reset");
    endtask

    task automatic test_all_zero();
        do_reset();
        for (int i = 0; i < 20; i++) send_info(1'b0, 1'b0, 0, "all_zero");
    endtask

    task automatic test_pattern();
        logic [3:0] info;
        do_reset();
        info = 4'b1101;
        for (int i = 0; i < 4; i++) send_info(info[i], 1'b0, 0, "pattern");
        for (int i = 0; i < 20; i++) send_info(1'b0, 1'b0, 0, "pattern");
    endtask

    task automatic test_single_error();
        logic [3:0] info;
        do_reset();
        info = 4'b1101;
        for (int i = 0; i < 4; i++)
            send_info(info[i], (i == 1), (i == 1) ? 1 : 0, "single_err");
        for (int i = 0; i < 20; i++) send_info(1'b0, 1'b0, 0, "single_err");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 200; i++) send_info(1'($urandom_range(0, 1)), 1'b0, 0, "random");
        for (int i = 0; i < D; i++) send_info(1'b0, 1'b0, 0, "random_tail");
        n_cmp++;
        if (exp_q.size() != D - 1) begin
            n_bad++;
            $display("FAIL random_drain: got %0d pending bits, want %0d", exp_q.size(), D - 1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 20; i++) send_info(1'b1, 1'b0, 0, "pre_reset");
        clk_bit(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bench_clear();
        check_zero_outputs("mid_reset");
        for (int i = 0; i < 20; i++) send_info(1'b0, 1'b0, 0, "post_reset");
    endtask

    task automatic test_const_ones();
        do_reset();
        err_pulses = 0;
        for (int i = 0; i < 100; i++) send_sym(1'b1, 1'b1, 1'b0, 1'b0, 2, "const_ones");
        n_cmp++;
        if (err_pulses < 20) begin
            n_bad++;
            $display("FAIL const_ones_pulses: got %0d error pulses, want at least 20", err_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_pattern();
        test_single_error();
        test_random();
        test_mid_reset();
        test_const_ones();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
